time_counter: RTL and testbench

TIME_COUNTER -- requirements
Module: time_counter

---
 rtl/clock_pkg.sv | 39 +++
 rtl/bcd_digit.sv | 45 ++++
 rtl/time_counter.sv | 123 ++++++++++++
 tb/tb_time_counter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared limits and helpers for the 24-hour BCD clock blocks.
// The legality check is reused by the alarm-register block.
package clock_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] MAX_MS_HR      = 4'd2;
  localparam logic [DIGIT_W-1:0] MAX_LS_HR_AT_2 = 4'd3;
  localparam logic [DIGIT_W-1:0] MAX_MS_MIN     = 4'd5;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT      = 4'd9;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef struct packed {
    digit_t ms_hr;
    digit_t ls_hr;
    digit_t ms_min;
    digit_t ls_min;
  } bcd_time_t;

  // True when the four digits form a valid HH:MM in 24-hour time.
  function automatic logic is_legal_time(bcd_time_t t);
    logic hr_ok;
    logic min_ok;
    if (t.ms_hr == MAX_MS_HR) begin
      hr_ok = (t.ls_hr <= MAX_LS_HR_AT_2);
    end else begin
      hr_ok = (t.ms_hr < MAX_MS_HR) && (t.ls_hr <= MAX_DIGIT);
    end
    min_ok = (t.ms_min <= MAX_MS_MIN) && (t.ls_min <= MAX_DIGIT);
    return hr_ok && min_ok;
  endfunction

  // True for hour 23, the only hour whose carry wraps both hour digits.
  function automatic logic is_last_hour(bcd_time_t t);
    return (t.ms_hr == MAX_MS_HR) && (t.ls_hr == MAX_LS_HR_AT_2);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: mod-(max_val+1) counter with load, clear and enable, plus carry-out.
// Priority is load, then clear, then count.
module bcd_digit
  import clock_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic [DIGIT_W-1:0] max_val,
  output logic [DIGIT_W-1:0] count,
  output logic               carry_out
);

  logic [DIGIT_W-1:0] count_d;
  logic [DIGIT_W-1:0] count_q;
  logic               at_max;

  assign at_max = (count_q >= max_val);

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = at_max ? '0 : count_q + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign carry_out = en && at_max;

endmodule

// File: rtl/time_counter.sv
// 24-hour HH:MM BCD time-of-day counter with validated load and day-wrap pulse.
// Load beats the minute tick; an illegal load keeps the time and flags load_error.
module time_counter
  import clock_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               one_minute,
  input  logic               load_new_c,
  input  logic [DIGIT_W-1:0] new_current_time_ms_hr,
  input  logic [DIGIT_W-1:0] new_current_time_ls_hr,
  input  logic [DIGIT_W-1:0] new_current_time_ms_min,
  input  logic [DIGIT_W-1:0] new_current_time_ls_min,
  output logic [DIGIT_W-1:0] current_time_ms_hr,
  output logic [DIGIT_W-1:0] current_time_ls_hr,
  output logic [DIGIT_W-1:0] current_time_ms_min,
  output logic [DIGIT_W-1:0] current_time_ls_min,
  output logic               day_wrap,
  output logic               load_error
);

  bcd_time_t new_time;
  bcd_time_t cur_time;
  logic      load_legal;
  logic      do_load;
  logic      tick;
  logic      ls_min_carry;
  logic      ms_min_carry;
  logic      ls_hr_carry;
  logic      ms_hr_carry;
  logic      hour_wrap;
  logic      day_wrap_d;
  logic      day_wrap_q;
  logic      load_error_d;
  logic      load_error_q;

  assign new_time = '{ms_hr:  new_current_time_ms_hr,
                      ls_hr:  new_current_time_ls_hr,
                      ms_min: new_current_time_ms_min,
                      ls_min: new_current_time_ls_min};

  assign load_legal = is_legal_time(new_time);
  assign do_load    = load_new_c && load_legal;
  assign tick       = one_minute && !load_new_c;

  // 23 -> 00 is not a natural BCD carry, so both hour digits are cleared here.
  assign hour_wrap  = ms_min_carry && is_last_hour(cur_time);

  bcd_digit u_ls_min (
    .clock     (clock),
    .reset     (reset),
    .en        (tick),
    .clr       (1'b0),
    .load      (do_load),
    .load_val  (new_time.ls_min),
    .max_val   (MAX_DIGIT),
    .count     (cur_time.ls_min),
    .carry_out (ls_min_carry)
  );

  bcd_digit u_ms_min (
    .clock     (clock),
    .reset     (reset),
    .en        (ls_min_carry),
    .clr       (1'b0),
    .load      (do_load),
    .load_val  (new_time.ms_min),
    .max_val   (MAX_MS_MIN),
    .count     (cur_time.ms_min),
    .carry_out (ms_min_carry)
  );

  bcd_digit u_ls_hr (
    .clock     (clock),
    .reset     (reset),
    .en        (ms_min_carry),
    .clr       (hour_wrap),
    .load      (do_load),
    .load_val  (new_time.ls_hr),
    .max_val   (MAX_DIGIT),
    .count     (cur_time.ls_hr),
    .carry_out (ls_hr_carry)
  );

  bcd_digit u_ms_hr (
    .clock     (clock),
    .reset     (reset),
    .en        (ls_hr_carry),
    .clr       (hour_wrap),
    .load      (do_load),
    .load_val  (new_time.ms_hr),
    .max_val   (MAX_MS_HR),
    .count     (cur_time.ms_hr),
    .carry_out (ms_hr_carry)
  );

  always_comb begin
    day_wrap_d   = hour_wrap;
    load_error_d = load_new_c && !load_legal;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      day_wrap_q   <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      day_wrap_q   <= day_wrap_d;
      load_error_q <= load_error_d;
    end
  end

  assign current_time_ms_hr  = cur_time.ms_hr;
  assign current_time_ls_hr  = cur_time.ls_hr;
  assign current_time_ms_min = cur_time.ms_min;
  assign current_time_ls_min = cur_time.ls_min;
  assign day_wrap            = day_wrap_q;
  assign load_error          = load_error_q;

  // The hour-tens carry never fires on a legal time; it is left unconnected by design.
  logic unused_ms_hr_carry;
  assign unused_ms_hr_carry = ms_hr_carry;

endmodule

// File: tb/tb_time_counter.sv
// Scoreboard bench for time_counter: a minutes-of-day model pushes expected outputs
// per driven cycle; each test task pops and compares after the clock edge.
module tb_time_counter;

  typedef struct packed {
    logic        om;
    logic        ld;
    logic [15:0] t;
  } stim_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       one_minute = 1'b0;
  logic       load_new_c = 1'b0;
  logic [3:0] n_ms_hr = '0, n_ls_hr = '0, n_ms_min = '0, n_ls_min = '0;
  logic [3:0] c_ms_hr, c_ls_hr, c_ms_min, c_ls_min;
  logic       day_wrap, load_error;
  logic [17:0] got;

  int n_cmp = 0;
  int n_bad = 0;
  int model_min = 0;
  logic [17:0] sb[$];

  always #5 clock = ~clock;

  time_counter dut (
    .clock                   (clock),
    .reset                   (reset),
    .one_minute              (one_minute),
    .load_new_c              (load_new_c),
    .new_current_time_ms_hr  (n_ms_hr),
    .new_current_time_ls_hr  (n_ls_hr),
    .new_current_time_ms_min (n_ms_min),
    .new_current_time_ls_min (n_ls_min),
    .current_time_ms_hr      (c_ms_hr),
    .current_time_ls_hr      (c_ls_hr),
    .current_time_ms_min     (c_ms_min),
    .current_time_ls_min     (c_ls_min),
    .day_wrap                (day_wrap),
    .load_error              (load_error)
  );

  assign got = {c_ms_hr, c_ls_hr, c_ms_min, c_ls_min, day_wrap, load_error};

  function automatic logic [17:0] exp_vec(int m, logic dw, logic le);
    int hr = m / 60;
    int mn = m % 60;
    return {4'(hr / 10), 4'(hr % 10), 4'(mn / 10), 4'(mn % 10), dw, le};
  endfunction

  // Drive one cycle at the falling edge, update the model, push expectation,
  // then return just after the rising edge that samples it.
  task automatic drive(stim_t s);
    int d3 = int'(s.t[15:12]);
    int d2 = int'(s.t[11:8]);
    int d1 = int'(s.t[7:4]);
    int d0 = int'(s.t[3:0]);
    int hr = d3 * 10 + d2;
    logic legal;
    logic dw = 1'b0;
    logic le = 1'b0;
    @(negedge clock);
    one_minute = s.om;
    load_new_c = s.ld;
    {n_ms_hr, n_ls_hr, n_ms_min, n_ls_min} = s.t;
    legal = (d3 <= 9) && (d2 <= 9) && (d1 <= 5) && (d0 <= 9) && (hr <= 23);
    if (s.ld) begin
      if (legal) model_min = hr * 60 + d1 * 10 + d0;
      else le = 1'b1;
    end else if (s.om) begin
      model_min = (model_min + 1) % 1440;
      dw = (model_min == 0);
    end
    sb.push_back(exp_vec(model_min, dw, le));
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    stim_t s;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (got !== exp_vec(0, 1'b0, 1'b0)) begin
      n_bad++;
      $display("FAIL reset_hold got=%h exp=%h", got, exp_vec(0, 1'b0, 1'b0));
    end
    @(negedge clock);
    reset = 1'b0;
    model_min = 0;
    s = '{om: 1'b1, ld: 1'b0, t: 16'h0000};
    drive(s);
    n_cmp++;
    if (got !== sb[0]) begin
      n_bad++;
      $display("FAIL reset_first_tick got=%h exp=%h", got, sb[0]);
    end
    void'(sb.pop_front());
  endtask

  task automatic run_table(string name, stim_t tbl[]);
    logic [17:0] e;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s[%0d] got=%h exp=%h", name, i, got, e);
      end
    end
  endtask

  task automatic test_minute_carry();
    stim_t tbl[] = '{'{1'b0, 1'b1, 16'h1259}, '{1'b1, 1'b0, 16'h0},
                     '{1'b1, 1'b0, 16'h0}, '{1'b1, 1'b0, 16'h0},
                     '{1'b1, 1'b0, 16'h0}, '{1'b0, 1'b0, 16'h0}};
    run_table("minute_carry", tbl);
  endtask

  task automatic test_hour_carry();
    stim_t tbl[] = '{'{1'b0, 1'b1, 16'h0959}, '{1'b1, 1'b0, 16'h0},
                     '{1'b0, 1'b1, 16'h1959}, '{1'b1, 1'b0, 16'h0},
                     '{1'b0, 1'b0, 16'h0}};
    run_table("hour_carry", tbl);
  endtask

  task automatic test_day_rollover();
    stim_t tbl[] = '{'{1'b0, 1'b1, 16'h2359}, '{1'b1, 1'b0, 16'h0},
                     '{1'b0, 1'b0, 16'h0},    '{1'b0, 1'b1, 16'h0000},
                     '{1'b0, 1'b0, 16'h0}};
    run_table("day_rollover", tbl);
  endtask

  task automatic test_illegal_loads();
    stim_t tbl[] = '{'{1'b0, 1'b1, 16'h1030}, '{1'b0, 1'b1, 16'h2400},
                     '{1'b0, 1'b0, 16'h0},    '{1'b0, 1'b1, 16'h1960},
                     '{1'b0, 1'b0, 16'h0},    '{1'b0, 1'b1, 16'h2A00},
                     '{1'b0, 1'b0, 16'h0},    '{1'b0, 1'b1, 16'h0A00},
                     '{1'b0, 1'b0, 16'h0}};
    run_table("illegal_load", tbl);
  endtask

  task automatic test_collision();
    stim_t tbl[] = '{'{1'b1, 1'b1, 16'h0815}, '{1'b0, 1'b0, 16'h0},
                     '{1'b1, 1'b1, 16'h2500}, '{1'b0, 1'b0, 16'h0},
                     '{1'b1, 1'b0, 16'h0}};
    run_table("collision", tbl);
  endtask

  task automatic test_back_to_back();
    stim_t tbl[] = '{'{1'b0, 1'b1, 16'h1111}, '{1'b0, 1'b1, 16'h2360},
                     '{1'b0, 1'b1, 16'h0000}, '{1'b0, 1'b1, 16'h2359},
                     '{1'b0, 1'b1, 16'h3000}, '{1'b1, 1'b0, 16'h0},
                     '{1'b0, 1'b0, 16'h0}};
    run_table("back_to_back", tbl);
  endtask

  task automatic test_async_reset();
    stim_t s = '{om: 1'b0, ld: 1'b1, t: 16'h2359};
    drive(s);
    n_cmp++;
    if (got !== sb[0]) begin
      n_bad++;
      $display("FAIL async_preload got=%h exp=%h", got, sb[0]);
    end
    void'(sb.pop_front());
    @(negedge clock);
    load_new_c = 1'b0;
    one_minute = 1'b1;
    #2;
    reset = 1'b1;
    model_min = 0;
    #1;
    n_cmp++;
    if (got !== exp_vec(0, 1'b0, 1'b0)) begin
      n_bad++;
      $display("FAIL async_immediate got=%h exp=%h", got, exp_vec(0, 1'b0, 1'b0));
    end
    @(posedge clock);
    #1;
    n_cmp++;
    if (got !== exp_vec(0, 1'b0, 1'b0)) begin
      n_bad++;
      $display("FAIL async_held got=%h exp=%h", got, exp_vec(0, 1'b0, 1'b0));
    end
    @(negedge clock);
    one_minute = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    #1;
    n_cmp++;
    if (got !== exp_vec(0, 1'b0, 1'b0)) begin
      n_bad++;
      $display("FAIL async_after got=%h exp=%h", got, exp_vec(0, 1'b0, 1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_minute_carry();
    test_hour_carry();
    test_day_rollover();
    test_illegal_loads();
    test_collision();
    test_back_to_back();
    test_async_reset();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
